sim_uart_xcvr: RTL and testbench

- Full-duplex 8N1 UART transceiver used as the bench-side serial partner of the SoC UART pins.
- Host side: tx_start/tx_data handshake with tx_busy and tx_clear_req.
- Serial side: ser_tx drives the chip RX pad; ser_rx samples the chip TX pad.
- Received bytes are presented on rx_data with a one-cycle rx_valid strobe.

---
 rtl/sim_uart_pkg.sv | 32 +++
 rtl/sim_uart_xcvr_if.sv | 27 ++
 rtl/sim_uart_rx.sv | 119 +++++++++++
 rtl/sim_uart_xcvr.sv | 122 ++++++++++++
 tb/tb_sim_uart_xcvr.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_uart_pkg.sv
// Shared types and constants for the sim_uart_xcvr bench-side UART.
// SIM_UART_PARITY_EN adds a PARITY state to both FSMs (8E1 framing).
package sim_uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

`ifdef SIM_UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;
`endif

  // Even parity: the extra bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sim_uart_xcvr_if.sv
// Host-side interface of sim_uart_xcvr: TX request handshake and RX byte strobes.
interface sim_uart_xcvr_if;
  import sim_uart_pkg::*;

  // tx_start is a level request: a frame is accepted when tx_start=1 and
  // tx_clear_req=0 while the TX FSM is idle; after the frame tx_clear_req
  // stays high until tx_start is seen low, so one assertion sends one frame.
  // rx_valid / rx_frame_err are single-cycle strobes with no backpressure.
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_clear_req;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
  );

endinterface

// File: rtl/sim_uart_rx.sv
// UART receiver: 2-flop synchronizer plus mid-bit sampling FSM.
// With SIM_UART_PARITY_EN an even-parity bit is checked before the stop bit.
module sim_uart_rx
  import sim_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_frame_err_o,
  output rx_state_e            state_o
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]           sync_q;
  logic                 prev_q;
  rx_state_e            state_q;
  logic [15:0]          cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shreg_q;
`ifdef SIM_UART_PARITY_EN
  logic                 par_err_q;
`endif
  logic                 rx_s;

  assign rx_s    = sync_q[1];
  assign state_o = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q         <= 2'b11;
      prev_q         <= IDLE_LEVEL;
      state_q        <= RX_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      shreg_q        <= '0;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
`ifdef SIM_UART_PARITY_EN
      par_err_q      <= 1'b0;
`endif
    end else begin
      sync_q         <= {sync_q[0], ser_rx_i};
      prev_q         <= rx_s;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
`ifdef SIM_UART_PARITY_EN
          par_err_q <= 1'b0;
`endif
          if (prev_q == IDLE_LEVEL && rx_s == START_LEVEL) state_q <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= (rx_s == START_LEVEL) ? RX_DATA : RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 3'd1;
`ifdef SIM_UART_PARITY_EN
            if (idx_q == 3'd7) state_q <= RX_PARITY;
`else
            if (idx_q == 3'd7) state_q <= RX_STOP;
`endif
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef SIM_UART_PARITY_EN
        RX_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            par_err_q <= (rx_s != even_parity(shreg_q));
            state_q   <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
`ifdef SIM_UART_PARITY_EN
            if (rx_s == IDLE_LEVEL && !par_err_q) begin
`else
            if (rx_s == IDLE_LEVEL) begin
`endif
              rx_data_o  <= shreg_q;
              rx_valid_o <= 1'b1;
            end else begin
              rx_frame_err_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sim_uart_xcvr.sv
// Full-duplex UART transceiver (8N1; 8E1 when SIM_UART_PARITY_EN is defined).
// TX FSM lives here; the receiver is the sim_uart_rx sub-module.
module sim_uart_xcvr
  import sim_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic               clock,
  input  logic               reset,
  sim_uart_xcvr_if.slave     host,
  output logic               ser_tx,
  input  logic               ser_rx,
  output tx_state_e          tx_state_o,
  output rx_state_e          rx_state_o
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e            state_q;
  logic [15:0]          cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 ser_tx_q;
  logic                 busy_q;
  logic                 clear_q;

  assign ser_tx            = ser_tx_q;
  assign host.tx_busy      = busy_q;
  assign host.tx_clear_req = clear_q;
  assign tx_state_o        = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      ser_tx_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (clear_q && !host.tx_start) clear_q <= 1'b0;
          if (host.tx_start && !clear_q) begin
            data_q   <= host.tx_data;
            ser_tx_q <= START_LEVEL;
            busy_q   <= 1'b1;
            state_q  <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= '0;
            ser_tx_q <= data_q[0];
            state_q  <= TX_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef SIM_UART_PARITY_EN
              ser_tx_q <= even_parity(data_q);
              state_q  <= TX_PARITY;
`else
              ser_tx_q <= IDLE_LEVEL;
              state_q  <= TX_STOP;
`endif
            end else begin
              ser_tx_q <= data_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef SIM_UART_PARITY_EN
        TX_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= '0;
            ser_tx_q <= IDLE_LEVEL;
            state_q  <= TX_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        TX_STOP: begin
          // clear_req holds off a re-send until the host drops tx_start.
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            clear_q <= 1'b1;
            state_q <= TX_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        TX_DONE: state_q <= TX_IDLE;
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  sim_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clock          (clock),
    .reset          (reset),
    .ser_rx_i       (ser_rx),
    .rx_data_o      (host.rx_data),
    .rx_valid_o     (host.rx_valid),
    .rx_frame_err_o (host.rx_frame_err),
    .state_o        (rx_state_o)
  );

endmodule

// File: tb/tb_sim_uart_xcvr.sv
// Directed bench for sim_uart_xcvr (default 8N1 build): TX bit table,
// loopback, RX framing error, start-bit glitch and mid-frame reset.
module tb_sim_uart_xcvr;
  import sim_uart_pkg::*;

  localparam int CPB = 32;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;  // bit k = serial bit k: start, d0..d7, stop
  } vec_t;

  logic      clk;
  logic      rst;
  logic      ser_tx;
  logic      ser_rx;
  logic      loop_en;
  logic      rx_drv;
  tx_state_e tx_state;
  rx_state_e rx_state;

  sim_uart_xcvr_if bus ();

  sim_uart_xcvr #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .host       (bus.slave),
    .ser_tx     (ser_tx),
    .ser_rx     (ser_rx),
    .tx_state_o (tx_state),
    .rx_state_o (rx_state)
  );

  assign ser_rx = loop_en ? ser_tx : rx_drv;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid must match the next queued byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected no byte", bus.rx_data);
        end else begin
          check("rx_data_sb", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (bus.rx_frame_err) ferr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tx_frame_check(input vec_t v);
    logic [9:0] got;
    logic       seen;
    int         n;
    got = '0;
    @(negedge clk);
    bus.tx_data  = v.data;
    bus.tx_start = 1'b1;
    @(negedge clk);
    check("tx_busy_latency", 32'(bus.tx_busy), 32'd1);
    n = 1;
    for (int k = 0; k < 10; k++) begin
      while (n < k * CPB + CPB / 2) begin
        @(negedge clk);
        n++;
      end
      got[k] = ser_tx;
      if (k == 3) bus.tx_data = ~v.data;
    end
    check("tx_bits", 32'(got), 32'(v.bits));
    for (int i = 0; i < 3 * CPB; i++) begin
      if (!bus.tx_busy) break;
      @(negedge clk);
    end
    check("tx_busy_drop", 32'(bus.tx_busy), 32'd0);
    check("tx_clear_req_set", 32'(bus.tx_clear_req), 32'd1);
    seen = 1'b0;
    repeat (20 * CPB) begin
      @(negedge clk);
      if (bus.tx_busy) seen = 1'b1;
    end
    check("one_frame_per_start", 32'(seen), 32'd0);
    check("tx_clear_req_hold", 32'(bus.tx_clear_req), 32'd1);
    bus.tx_start = 1'b0;
    repeat (2) @(negedge clk);
    check("tx_clear_req_drop", 32'(bus.tx_clear_req), 32'd0);
  endtask

  task automatic tx_send(input logic [7:0] d);
    int i;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    for (i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.tx_busy) break;
    end
    if (i == 4) check("send_busy_rise", 32'(bus.tx_busy), 32'd1);
    for (i = 0; i < 12 * CPB; i++) begin
      @(negedge clk);
      if (!bus.tx_busy) break;
    end
    if (i == 12 * CPB) check("send_busy_fall", 32'(bus.tx_busy), 32'd0);
    bus.tx_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[5];
  int   v0, e0;

  initial begin
    tbl[0] = '{8'h0F, 10'b1_00001111_0};
    tbl[1] = '{8'h3D, 10'b1_00111101_0};
    tbl[2] = '{8'hA5, 10'b1_10100101_0};
    tbl[3] = '{8'h00, 10'b1_00000000_0};
    tbl[4] = '{8'hFF, 10'b1_11111111_0};

    rst          = 1'b1;
    loop_en      = 1'b0;
    rx_drv       = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    #2;
    check("rst_ser_tx", 32'(ser_tx), 32'd1);
    check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_tx_clear_req", 32'(bus.tx_clear_req), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_frame_err", 32'(bus.rx_frame_err), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven TX frames; 20000-cycle gap after the first one.
    for (int i = 0; i < 5; i++) begin
      tx_frame_check(tbl[i]);
      if (i == 0) repeat (20000) @(negedge clk);
    end
    check("tx_path_no_rx_activity", 32'(valid_cnt + ferr_cnt), 32'd0);

    // Loopback: alternate 0x0F / 0x3D, four times each.
    loop_en = 1'b1;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = (i % 2 == 0) ? 8'h0F : 8'h3D;
      exp_q.push_back(b);
      tx_send(b);
    end
    repeat (2 * CPB) @(negedge clk);
    check("loop_valid_count", 32'(valid_cnt - v0), 32'd8);
    check("loop_frame_err", 32'(ferr_cnt - e0), 32'd0);
    check("loop_queue_empty", 32'(exp_q.size()), 32'd0);
    loop_en = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Stop bit low: one-cycle frame error, rx_data keeps the last good byte.
    v0 = valid_cnt;
    e0 = ferr_cnt;
    rx_drive(8'hA5, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_pulse_cycles", 32'(ferr_cnt - e0), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_rx_data_kept", 32'(bus.rx_data), 32'h3D);
    check("ferr_rx_idle", 32'(rx_state), 32'(RX_IDLE));

    // Start-bit glitch of CPB/4 cycles, then a good 0x55 frame.
    v0 = valid_cnt;
    e0 = ferr_cnt;
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_rx_idle", 32'(rx_state), 32'(RX_IDLE));
    check("glitch_no_strobe", 32'(valid_cnt - v0 + ferr_cnt - e0), 32'd0);
    exp_q.push_back(8'h55);
    rx_drive(8'h55, 1'b1);
    repeat (CPB) @(negedge clk);
    check("after_glitch_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_glitch_data", 32'(bus.rx_data), 32'h55);
    check("after_glitch_no_err", 32'(ferr_cnt - e0), 32'd0);

    // Reset in the middle of a TX frame.
    @(negedge clk);
    bus.tx_data  = 8'hC3;
    bus.tx_start = 1'b1;
    repeat (3 * CPB + 5) @(negedge clk);
    check("pre_reset_tx_busy", 32'(bus.tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_ser_tx", 32'(ser_tx), 32'd1);
    check("mid_reset_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("mid_reset_tx_idle", 32'(tx_state), 32'(TX_IDLE));
    bus.tx_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tx_frame_check(tbl[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
